mips16_fetch_unit: RTL and testbench

//   Instruction fetch stage for the 16-bit MIPS core. It owns the fetch PC and issues

---
 rtl/mips16_fetch_if.sv | 40 ++++
 rtl/mips16_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_mips16_fetch_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips16_fetch_if.sv
// mips16_fetch_if: bundles the fetch-stage buses.
//   imem_*     : instruction memory read port (request/address out, data back)
//   redirect_* : branch/jump restart from downstream
//   out_*      : valid/ready instruction stream towards decode
//   perf_*     : delivered-instruction and starved-decode counters
// Modports: master = fetch unit side, slave = memory/decode/environment side.
interface mips16_fetch_if #(
  parameter int unsigned PC_W    = 13,
  parameter int unsigned INSTR_W = 16
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [15:0]        perf_fetched;
  logic [15:0]        perf_bubbles;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    input  redirect_valid, redirect_pc,
    output out_valid, out_instr, out_pc,
    input  out_ready,
    output perf_fetched, perf_bubbles
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    output redirect_valid, redirect_pc,
    input  out_valid, out_instr, out_pc,
    output out_ready,
    input  perf_fetched, perf_bubbles
  );
endinterface

// File: rtl/mips16_fetch_unit.sv
// mips16_fetch_unit: instruction fetch stage for the 16-bit MIPS core.
// Owns the fetch PC, issues word reads to a 1-cycle-latency instruction memory,
// buffers returned words (tagged with their PC) in a small prefetch FIFO and
// presents them to decode through valid/ready. A redirect flushes the FIFO,
// squashes the in-flight read and restarts fetch at redirect_pc.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - mips16_fetch_if.master (imem, redirect, out stream, perf counters)
// Optional feature: define FETCH_PERF_EN to build the perf_fetched/perf_bubbles
// saturating counters; otherwise both read as zero and no counter flops exist.
module mips16_fetch_unit #(
  parameter int unsigned    PC_W       = 13,
  parameter int unsigned    INSTR_W    = 16,
  parameter int unsigned    FIFO_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             rst,
  mips16_fetch_if.master   bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Fetch PC and the single outstanding read
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic               inflight_q, inflight_d;
  logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;

  // Prefetch FIFO
  logic [INSTR_W-1:0] instr_mem_q [FIFO_DEPTH];
  logic [PC_W-1:0]    pc_mem_q    [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic issue_c;
  logic push_c;
  logic pop_c;
  logic out_valid_c;

  // Credits include the outstanding read so a returning word always has a slot
  assign issue_c = !rst && !bus.redirect_valid &&
                   ((32'(count_q) + 32'(inflight_q)) < FIFO_DEPTH);

  // A response landing in a redirect cycle belongs to the old path and is dropped
  assign push_c      = inflight_q && !bus.redirect_valid;
  assign out_valid_c = (count_q != '0);
  assign pop_c       = out_valid_c && bus.out_ready;

  assign bus.imem_req  = issue_c;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = out_valid_c;
  assign bus.out_instr = out_valid_c ? instr_mem_q[rd_ptr_q] : '0;
  assign bus.out_pc    = out_valid_c ? pc_mem_q[rd_ptr_q]    : '0;

  // Next-state: flush on redirect, otherwise FIFO push/pop and issue
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (bus.redirect_valid) begin
      // The head handshake of this cycle still completes; everything else goes
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = bus.redirect_pc;
    end else begin
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (issue_c) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        // Natural truncation wraps the PC at 2^PC_W
        fetch_pc_d    = fetch_pc_q + PC_W'(1);
      end
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage; contents are qualified by count so no reset is needed
  always_ff @(posedge clk) begin
    if (push_c) begin
      instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched_q;
  logic [15:0] perf_bubbles_q;

  // Saturating counters; only reset clears them, redirect leaves them alone
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      if (pop_c && (perf_fetched_q != 16'hFFFF)) begin
        perf_fetched_q <= perf_fetched_q + 16'd1;
      end
      if (bus.out_ready && !out_valid_c && (perf_bubbles_q != 16'hFFFF)) begin
        perf_bubbles_q <= perf_bubbles_q + 16'd1;
      end
    end
  end

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_bubbles = perf_bubbles_q;
`else
  assign bus.perf_fetched = '0;
  assign bus.perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_mips16_fetch_unit.sv
// tb_mips16_fetch_unit: directed scenarios plus randomized traffic for the fetch
// unit, checked every cycle against a queue-based transaction model.
module tb_mips16_fetch_unit;

  localparam int PC_W    = 13;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 4;
  localparam int PC_MOD  = 1 << PC_W;
`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips16_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bif ();

  mips16_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .FIFO_DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  function automatic logic [15:0] imem_word(input int pc);
    return 16'(pc + 32'h1000);
  endfunction

  // Instruction memory: 1-cycle latency, garbage when not requested
  always @(posedge clk) begin
    if (bif.imem_req) bif.imem_rdata <= imem_word(int'(bif.imem_addr));
    else              bif.imem_rdata <= 16'($urandom);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: visible FIFO as a PC queue, one pending read, counters
  int m_q[$];
  bit m_infl;
  int m_infl_pc;
  int m_pc;
  int m_fetched;
  int m_bub;

  // Drive values for the current cycle
  bit d_rst, d_ready, d_redir;
  int d_rpc;

  task automatic model_reset();
    m_q.delete();
    m_infl = 0; m_infl_pc = 0; m_pc = 0; m_fetched = 0; m_bub = 0;
  endtask

  // One cycle: apply inputs at negedge, compare, then advance model across posedge
  task automatic cycle();
    bit e_valid, e_req, hs;
    @(negedge clk);
    rst                = d_rst;
    bif.out_ready      = d_ready;
    bif.redirect_valid = d_redir;
    bif.redirect_pc    = PC_W'(d_rpc);
    #1;
    e_valid = (m_q.size() > 0);
    e_req   = !d_rst && !d_redir && ((m_q.size() + int'(m_infl)) < DEPTH);
    chk("imem_req", 32'(bif.imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", 32'(bif.imem_addr), 32'(m_pc));
    chk("out_valid", 32'(bif.out_valid), 32'(e_valid));
    chk("out_pc", 32'(bif.out_pc), e_valid ? 32'(m_q[0]) : 32'd0);
    chk("out_instr", 32'(bif.out_instr), e_valid ? 32'(imem_word(m_q[0])) : 32'd0);
    chk("perf_fetched", 32'(bif.perf_fetched), PERF ? 32'(m_fetched) : 32'd0);
    chk("perf_bubbles", 32'(bif.perf_bubbles), PERF ? 32'(m_bub) : 32'd0);
    if (d_rst) begin
      model_reset();
    end else begin
      hs = e_valid && d_ready;
      if (hs && m_fetched < 16'hFFFF) m_fetched++;
      if (d_ready && !e_valid && m_bub < 16'hFFFF) m_bub++;
      if (d_redir) begin
        m_q.delete();
        m_infl = 0;
        m_pc   = d_rpc % PC_MOD;
      end else begin
        if (hs) void'(m_q.pop_front());
        if (m_infl) m_q.push_back(m_infl_pc);
        m_infl = e_req;
        if (e_req) begin
          m_infl_pc = m_pc;
          m_pc      = (m_pc + 1) % PC_MOD;
        end
      end
    end
  endtask

  initial begin
    int got[$];
    bit seen;
    model_reset();
    d_rst = 1; d_ready = 1; d_redir = 0; d_rpc = 0;
    rst = 1; bif.out_ready = 1; bif.redirect_valid = 0; bif.redirect_pc = '0;
    repeat (2) @(posedge clk);

    // Reset state and first-fetch timing with decode always ready
    cycle();
    chk("rst_imem_req", 32'(bif.imem_req), 32'd0);
    chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
    d_rst = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (k == 0) begin
        chk("c0_req", 32'(bif.imem_req), 32'd1);
        chk("c0_addr", 32'(bif.imem_addr), 32'd0);
      end
      if (k == 1) chk("c1_valid", 32'(bif.out_valid), 32'd0);
      if (k >= 2) begin
        chk("stream_valid", 32'(bif.out_valid), 32'd1);
        chk("stream_pc", 32'(bif.out_pc), 32'(k - 2));
        chk("stream_instr", 32'(bif.out_instr), 32'h1000 + 32'(k - 2));
      end
      if (k == 2) chk("bubbles_c2", 32'(bif.perf_bubbles), PERF ? 32'd2 : 32'd0);
      if (k == 9) chk("fetched_c9", 32'(bif.perf_fetched), PERF ? 32'd7 : 32'd0);
    end

    // Reset mid-stream: everything zero the following cycle
    d_rst = 1;
    cycle();
    chk("midrst_req", 32'(bif.imem_req), 32'd0);
    cycle();
    chk("midrst_valid", 32'(bif.out_valid), 32'd0);
    chk("midrst_pc", 32'(bif.out_pc), 32'd0);
    chk("midrst_instr", 32'(bif.out_instr), 32'd0);
    chk("midrst_fetched", 32'(bif.perf_fetched), 32'd0);
    chk("midrst_bubbles", 32'(bif.perf_bubbles), 32'd0);

    // Output stall: issue stops once 4 words are held or in flight
    d_rst = 0; d_ready = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (k < 4)  chk("stall_issue", 32'(bif.imem_req), 32'd1);
      if (k >= 4) chk("stall_noissue", 32'(bif.imem_req), 32'd0);
    end
    d_ready = 1;
    cycle();
    chk("release_pc", 32'(bif.out_pc), 32'd0);

    // Redirect coinciding with the handshake of PC 5
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cycle();
      seen = (m_q.size() > 0) && (m_q[0] == 5);
    end
    if (!seen) begin n_cmp++; n_bad++; $display("FAIL wait_pc5: timeout expected head 5"); end
    d_redir = 1; d_rpc = 'h100;
    cycle();
    chk("redir_hs_pc", 32'(bif.out_pc), 32'd5);
    chk("redir_hs_valid", 32'(bif.out_valid), 32'd1);
    chk("redir_req", 32'(bif.imem_req), 32'd0);
    d_redir = 0;
    cycle(); chk("redir_gap1", 32'(bif.out_valid), 32'd0);
    cycle(); chk("redir_gap2", 32'(bif.out_valid), 32'd0);
    cycle();
    chk("redir_tgt_pc", 32'(bif.out_pc), 32'h100);
    chk("redir_tgt_instr", 32'(bif.out_instr), 32'h1100);

    // Redirect while the FIFO is full and stalled
    d_ready = 0;
    repeat (8) cycle();
    d_redir = 1; d_rpc = 'h200;
    cycle();
    d_redir = 0; d_ready = 1;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      cycle();
      seen = bif.out_valid;
    end
    if (!seen) begin n_cmp++; n_bad++; $display("FAIL wait_flush_tgt: timeout expected valid"); end
    chk("flush_tgt_pc", 32'(bif.out_pc), 32'h200);

    // Redirect near the top of the PC space: delivery wraps to 0
    d_redir = 1; d_rpc = 'h1FFE;
    cycle();
    d_redir = 0;
    got.delete();
    for (int k = 0; k < 20 && got.size() < 4; k++) begin
      cycle();
      if (bif.out_valid && d_ready) got.push_back(int'(bif.out_pc));
    end
    if (got.size() < 4) begin
      n_cmp++; n_bad++; $display("FAIL wrap_count: got %0d words expected 4", got.size());
    end else begin
      chk("wrap0", 32'(got[0]), 32'h1FFE);
      chk("wrap1", 32'(got[1]), 32'h1FFF);
      chk("wrap2", 32'(got[2]), 32'h0000);
      chk("wrap3", 32'(got[3]), 32'h0001);
    end

    // Randomized traffic: ready stalls, pulsed/held redirects, occasional reset
    for (int k = 0; k < 3000; k++) begin
      d_ready = ($urandom_range(0, 9) < 7);
      if (d_redir && $urandom_range(0, 1) == 0) d_redir = 1;
      else d_redir = ($urandom_range(0, 19) == 0);
      d_rpc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(PC_MOD - 3, PC_MOD - 1))
                                          : int'($urandom_range(0, PC_MOD - 1));
      d_rst = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
